// File: rtl/sram_ctrl.sv
// Memory-port controller for an external asynchronous 16-bit SRAM with programmable wait states.
// Word accesses are split into two halfword beats; all outputs are registered.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r,
  input  logic               mem_w,
  input  logic               fetch,
  input  logic [1:0]         mem_sz,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_busy,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t             state, state_d;
  logic [3:0]         cnt, cnt_d;
  logic [SRAM_AW-1:0] lat_hw, hw_d;
  size_t              lat_sz, sz_d;
  logic               lat_wr, wr_d;
  logic               lat_ub, ub_d;
  logic [31:0]        lat_wdata, wdata_d;
  logic [15:0]        lo_half;
  logic               accept, beat_last, in_beat, in_beat_d;

  // Address bits above the SRAM's reach are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^mem_addr[31:SRAM_AW+1];

  assign in_beat   = (state == BEAT_LO) || (state == BEAT_HI);
  assign beat_last = (cnt == WAIT_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    accept  = ((state == IDLE) || (state == DONE)) && (mem_r || mem_w || fetch);
    hw_d    = lat_hw;
    sz_d    = lat_sz;
    wr_d    = lat_wr;
    ub_d    = lat_ub;
    wdata_d = lat_wdata;
    if (accept) begin
      wdata_d = mem_wdata;
      ub_d    = mem_addr[0];
      if (fetch) begin
        sz_d = SZ_WORD;
        wr_d = 1'b0;
      end else begin
        wr_d = mem_w;
        case (mem_sz)
          2'd0:    sz_d = SZ_BYTE;
          2'd1:    sz_d = SZ_HALF;
          default: sz_d = SZ_WORD;
        endcase
      end
      hw_d = mem_addr[SRAM_AW:1];
      if (sz_d == SZ_WORD) hw_d[0] = 1'b0;
    end

    state_d = state;
    case (state)
      IDLE, DONE: state_d = accept ? BEAT_LO : IDLE;
      BEAT_LO:    if (beat_last) state_d = (lat_sz == SZ_WORD) ? BEAT_HI : DONE;
      BEAT_HI:    if (beat_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    // The counter restarts on every state change, so it reloads at each beat start and never wraps.
    cnt_d     = ((state_d == state) && in_beat) ? cnt + 4'd1 : 4'd0;
    in_beat_d = (state_d == BEAT_LO) || (state_d == BEAT_HI);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_hw     <= '0;
      lat_sz     <= SZ_BYTE;
      lat_wr     <= 1'b0;
      lat_ub     <= 1'b0;
      lat_wdata  <= '0;
      lo_half    <= '0;
      mem_rdata  <= '0;
      mem_busy   <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      lat_hw    <= hw_d;
      lat_sz    <= sz_d;
      lat_wr    <= wr_d;
      lat_ub    <= ub_d;
      lat_wdata <= wdata_d;

      // Strobes are computed from next-state values so the pads change exactly at beat boundaries.
      mem_busy   <= in_beat_d;
      sram_ce_n  <= !in_beat_d;
      sram_oe_n  <= !(in_beat_d && !wr_d);
      sram_dq_oe <= in_beat_d && wr_d;
      sram_we_n  <= !(in_beat_d && wr_d && (cnt_d != WAIT_LAST));
      if (in_beat_d && (sz_d == SZ_BYTE)) begin
        sram_ub_n <= !ub_d;
        sram_lb_n <= ub_d;
      end else begin
        sram_ub_n <= !in_beat_d;
        sram_lb_n <= !in_beat_d;
      end

      if (in_beat_d) begin
        sram_addr <= (state_d == BEAT_HI) ? {hw_d[SRAM_AW-1:1], 1'b1} : hw_d;
        case (sz_d)
          SZ_BYTE: sram_dq_o <= {wdata_d[7:0], wdata_d[7:0]};
          SZ_WORD: sram_dq_o <= (state_d == BEAT_HI) ? wdata_d[31:16] : wdata_d[15:0];
          default: sram_dq_o <= wdata_d[15:0];
        endcase
      end

      // Read lanes are sampled at the edge that ends the last cycle of a beat.
      if (in_beat && beat_last && !lat_wr) begin
        if (state == BEAT_HI) begin
          mem_rdata <= {sram_dq_i, lo_half};
        end else begin
          case (lat_sz)
            SZ_BYTE: mem_rdata <= {24'b0, lat_ub ? sram_dq_i[15:8] : sram_dq_i[7:0]};
            SZ_HALF: mem_rdata <= {16'b0, sram_dq_i};
            default: lo_half   <= sram_dq_i;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: word/byte/half accesses, back-to-back, reset abort, idle, wait sweep.
// Two instances: WAIT_CYCLES=1 for most steps, WAIT_CYCLES=3 for the sweep; one shared SRAM model.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r, mem_w, fetch;
  logic [1:0]  mem_sz;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic        mem_r3, mem_w3, fetch3;
  logic [31:0] rdata3;
  logic        busy3;
  logic [17:0] a3_addr;
  logic [15:0] a3_dq_o, a3_dq_i;
  logic        a3_dq_oe, a3_ce_n, a3_oe_n, a3_we_n, a3_ub_n, a3_lb_n;

  logic [15:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(18)) u_dut (
    .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .fetch(fetch),
    .mem_sz(mem_sz), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_ctrl #(.WAIT_CYCLES(3), .SRAM_AW(18)) u_dut3 (
    .clk(clk), .rst(rst), .mem_r(mem_r3), .mem_w(mem_w3), .fetch(fetch3),
    .mem_sz(mem_sz), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(rdata3), .mem_busy(busy3), .sram_addr(a3_addr),
    .sram_dq_o(a3_dq_o), .sram_dq_i(a3_dq_i), .sram_dq_oe(a3_dq_oe),
    .sram_ce_n(a3_ce_n), .sram_oe_n(a3_oe_n), .sram_we_n(a3_we_n),
    .sram_ub_n(a3_ub_n), .sram_lb_n(a3_lb_n)
  );

  // Asynchronous SRAM: reads are combinational, writes land while ce_n and we_n are low.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
  assign a3_dq_i   = (!a3_ce_n && !a3_oe_n) ? mem[a3_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents one request for a single edge; returns at the negedge of the first busy cycle.
  task automatic start_req(input logic r, input logic w, input logic f, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_r = r; mem_w = w; fetch = f; mem_sz = sz; mem_addr = a; mem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0; fetch = 1'b0;
  endtask

  // Follows an access until mem_busy drops; returns at the negedge of the DONE cycle.
  task automatic watch(output int n, output logic [31:0] addrs, output int we_low,
                       output logic [15:0] dq0, output logic [1:0] lanes0);
    n = 0; addrs = '0; we_low = 0;
    dq0    = sram_dq_o;
    lanes0 = {sram_ub_n, sram_lb_n};
    while (mem_busy && n < 40) begin
      addrs = {addrs[23:0], sram_addr[7:0]};
      if (!sram_we_n) we_low++;
      n++;
      @(negedge clk);
    end
    check("busy_bounded", 32'(n < 40), 32'd1);
  endtask

  int          n, wl;
  logic [31:0] addrs;
  logic [15:0] dq0;
  logic [1:0]  lanes0;

  initial begin
    rst = 1'b1; mem_r = 1'b0; mem_w = 1'b0; fetch = 1'b0; mem_sz = 2'd0;
    mem_addr = '0; mem_wdata = '0; mem_r3 = 1'b0; mem_w3 = 1'b0; fetch3 = 1'b0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (3) @(negedge clk);

    check("rst_busy",   mem_busy,   1'b0);
    check("rst_rdata",  mem_rdata,  32'h0);
    check("rst_addr",   sram_addr,  18'h0);
    check("rst_dq",     sram_dq_o,  16'h0);
    check("rst_dq_oe",  sram_dq_oe, 1'b0);
    check("rst_strobe", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    rst = 1'b0;

    poke(8'h80, 16'h5678);
    poke(8'h81, 16'h1234);
    poke(8'h00, 16'h1111);
    poke(8'h01, 16'h2222);

    // Word read at 0x100.
    start_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    watch(n, addrs, wl, dq0, lanes0);
    check("wrd_busy_cycles", n, 4);
    check("wrd_addr_seq",    addrs, 32'h80808181);
    check("wrd_lanes",       lanes0, 2'b00);
    check("wrd_done_busy",   mem_busy, 1'b0);
    check("wrd_rdata",       mem_rdata, 32'h12345678);

    // Byte read at 0x103: upper lane of halfword 0x81.
    start_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h103, 32'h0);
    watch(n, addrs, wl, dq0, lanes0);
    check("brd_busy_cycles", n, 2);
    check("brd_addr_seq",    addrs, 32'h00008181);
    check("brd_lanes",       lanes0, 2'b01);
    check("brd_rdata",       mem_rdata, 32'h00000012);

    // Byte write 0xAB at 0x101.
    start_req(1'b0, 1'b1, 1'b0, 2'd0, 32'h101, 32'hFFFFFFAB);
    watch(n, addrs, wl, dq0, lanes0);
    check("bwr_busy_cycles", n, 2);
    check("bwr_addr_seq",    addrs, 32'h00008080);
    check("bwr_dq",          dq0, 16'hABAB);
    check("bwr_lanes",       lanes0, 2'b01);
    check("bwr_we_low",      wl, 1);
    check("bwr_sram",        mem[8'h80], 16'hAB78);
    check("bwr_rdata_hold",  mem_rdata, 32'h00000012);

    // Fetch from 0x0 with a half write to 0x10 queued behind it.
    start_req(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    mem_w = 1'b1; mem_sz = 2'd1; mem_addr = 32'h10; mem_wdata = 32'h1234BEEF;
    n = 0;
    while (mem_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("b2b_fetch_busy",  n, 4);
    check("b2b_fetch_rdata", mem_rdata, 32'h22221111);
    check("b2b_done_busy",   mem_busy, 1'b0);
    @(negedge clk);
    check("b2b_gap_one",     mem_busy, 1'b1);
    check("b2b_wr_addr",     sram_addr, 18'h08);
    check("b2b_wr_we",       sram_we_n, 1'b0);
    mem_w = 1'b0;
    n = 1;
    @(negedge clk);
    while (mem_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("b2b_wr_busy",     n, 2);
    check("b2b_wr_sram",     mem[8'h08], 16'hBEEF);

    // Reset in the second cycle of BEAT_HI of a word read.
    start_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    check("rmid_in_hi",      sram_addr, 18'h81);
    rst = 1'b1;
    @(negedge clk);
    check("rmid_strobe", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("rmid_busy",       mem_busy, 1'b0);
    check("rmid_rdata",      mem_rdata, 32'h0);
    rst = 1'b0;

    // Half read at 0x102 after the abort.
    start_req(1'b1, 1'b0, 1'b0, 2'd1, 32'h102, 32'h0);
    watch(n, addrs, wl, dq0, lanes0);
    check("hrd_busy_cycles", n, 2);
    check("hrd_rdata",       mem_rdata, 32'h00001234);

    // Idle: no requests for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      check("idle_busy_ce", {mem_busy, sram_ce_n}, 2'b01);
    end

    // Word read with three wait states.
    @(negedge clk);
    mem_r3 = 1'b1; mem_sz = 2'd2; mem_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    mem_r3 = 1'b0;
    n = 0;
    while (busy3 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("w3_busy_cycles",  n, 8);
    check("w3_rdata",        rdata3, 32'h1234AB78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side controller for the unified memory port: accepts one sized read/write request at a time from the instruction/data arbiter. Executes it on an external asynchronous 16-bit SRAM with programmable wait states. Word accesses are split into two halfword beats. Returns right-aligned, zero-extended read data while holding `mem_busy` high until the access completes.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles per SRAM beat; legal range 1..15.
- `SRAM_AW`, default 18: SRAM halfword address width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_r` in 1: read request.
- `mem_w` in 1: write request; wins if both `mem_r` and `mem_w` are high.
- `fetch` in 1: instruction fetch; forces a word read regardless of `mem_sz`/`mem_w`.
- `mem_sz` in 2: access size; 0 = byte, 1 = half, 2 or 3 = word.
- `mem_addr` in 32: byte address; low bits forced to size alignment; bits above `SRAM_AW`+1 ignored.
- `mem_wdata` in 32: write data, right-aligned.
- `mem_rdata` out 32: read data, right-aligned, zero-extended.
- `mem_busy` out 1: access in progress; requester must hold its request stable.
- `sram_addr` out `SRAM_AW`: halfword address.
- `sram_dq_o` out 16: write data to pads.
- `sram_dq_i` in 16: read data from pads.
- `sram_dq_oe` out 1: pad output enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low strobes.

## Operation
- **States:** IDLE, BEAT_LO, BEAT_HI, DONE. A 4-bit wait counter counts within a beat.
- **Acceptance:** a request is accepted at a rising edge when the state is IDLE or DONE and (`mem_r`|`mem_w`|`fetch`).
  - Address, size, direction and write data are latched at acceptance.
  - Inputs are ignored while busy.
- **Beat mapping (little-endian):** halfword address is `mem_addr[SRAM_AW:1]`.
  - Word: BEAT_LO at `{addr[SRAM_AW:2],0}` with both lanes, then BEAT_HI at `{addr[SRAM_AW:2],1}` with both lanes.
  - Half: one beat (BEAT_LO), both lanes.
  - Byte: one beat; `addr[0]`=0 selects lb lane, `addr[0]`=1 selects ub lane.
- **Write data:**
  - Word: low beat drives `wdata[15:0]`, high beat drives `wdata[31:16]`.
  - Half: drives `wdata[15:0]`.
  - Byte: `{wdata[7:0],wdata[7:0]}` on both lanes; unused lane masked by its `_n` strobe.
- **Read data:**
  - The enabled lane(s) are captured on the final cycle of each beat.
  - Word result is `{hi,lo}`; half result is `{16'b0,dq}`; byte result is `{24'b0, selected lane}`.
- **`mem_rdata` hold:** holds its value until the next read completes. Writes leave it unchanged.
- **Strobes during a beat:**
  - `ce_n`=0, lane strobes active, `sram_addr` stable for all `WAIT_CYCLES`+1 cycles.
  - Reads: `oe_n`=0, `dq_oe`=0.
  - Writes: `oe_n`=1, `dq_oe`=1 for the whole beat; `we_n`=0 on all beat cycles except the last, which holds data and address.
- **DONE:** strobes deasserted, `mem_busy`=0, read data valid. Returns to IDLE if there is no new request.

## Timing
- **Reset:** state IDLE, counter 0, `mem_busy`=0, `mem_rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, all `_n` strobes 1.
- **Registered outputs:** all outputs are registered; there is no combinational path from request inputs to any output.
- **Beat length:** each beat is `WAIT_CYCLES`+1 cycles.
- **`mem_busy` high time:** `WAIT_CYCLES`+1 cycles for byte/half, 2·(`WAIT_CYCLES`+1) for word. It starts in the cycle after acceptance.
- **Response cycle:** the first cycle after `mem_busy` falls is DONE; `mem_rdata` is valid there.
- **Back-to-back:** a request present in DONE is accepted at the DONE→next edge; there is no dead cycle beyond DONE.
- **Idle:** `mem_busy` stays 0 with no request.
- **BEAT_LO→BEAT_HI:** address changes with no strobe gap; `we_n` is high on the boundary cycle.
- **Reset mid-access:** the access is aborted at that edge and all strobes are deasserted next cycle. No data is returned and `mem_rdata` becomes 0.
- **Counter:** never wraps. It reloads to 0 at each beat start and terminates at `WAIT_CYCLES`.

## Test plan
- **Word read:** `WAIT_CYCLES`=1; SRAM[0x80]=0x5678, SRAM[0x81]=0x1234; word read at 0x100.
  - `sram_addr` is 0x80 for 2 cycles, then 0x81 for 2 cycles.
  - `mem_busy` is high for 4 cycles, then `mem_rdata`=0x12345678.
- **Byte read:** byte read at 0x103 with SRAM[0x81]=0x1234 → `ub_n`=0, `lb_n`=1, `mem_rdata`=0x00000012 after 2 busy cycles.
- **Byte write:** byte write 0xAB at 0x101 → `sram_addr`=0x80, `sram_dq_o`=0xABAB, `ub_n`=0, `lb_n`=1.
  - `we_n` is low for exactly 1 cycle.
  - SRAM model then reads 0xAB?? with the low byte unchanged.
- **Back-to-back:** fetch from 0x0 immediately followed by a half write at 0x10.
  - Second request is accepted in the DONE cycle of the first.
  - `mem_busy` is low for exactly 1 cycle between them.
- **Reset mid-word:** `rst` asserted in the 2nd cycle of BEAT_HI.
  - Next cycle: all strobes 1, `mem_busy`=0, `mem_rdata`=0.
  - A subsequent read succeeds normally.
- **Idle and wait sweep:**
  - No requests for 20 cycles → `mem_busy`=0 and `ce_n`=1 throughout.
  - Repeat a word read with `WAIT_CYCLES`=3 → 8 busy cycles.
